// File: rtl/lifo_stream_drain_if.sv
// Valid/ready stream carrying entries drained from the LIFO.
// The master drives valid and data; the slave drives ready.
interface lifo_stream_drain_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/lifo_stream_drain.sv
// Drains a registered-read LIFO onto a valid/ready stream through a
// 2-entry prefetch buffer, with a flush mode that discards and counts.
module lifo_stream_drain #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] lifo_data_rd,
   input  logic                  lifo_empty,
   output logic                  lifo_rd_en,
   lifo_stream_drain_if.master   m,
   input  logic                  flush,
   output logic                  flush_busy,
   output logic [CNT_WIDTH-1:0]  drop_cnt
);

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   logic [0:0]            state_r;
   logic [1:0]            buf_cnt_r;
   logic                  inflight_r;
   logic [DATA_WIDTH-1:0] buf0_r;
   logic [DATA_WIDTH-1:0] buf1_r;
   logic [1:0]            drop_pend_r;
   logic [CNT_WIDTH-1:0]  drop_cnt_r;

   logic                  m_valid_s;
   logic                  xfer_s;
   logic                  rd_en_s;
   logic [1:0]            cnt_after_xfer_s;
   logic [2:0]            occ_s;

   function automatic logic [CNT_WIDTH-1:0] sat_add(
      input logic [CNT_WIDTH-1:0] base,
      input logic [1:0]           pend,
      input logic                 one
   );
      logic [CNT_WIDTH+1:0] sum;
      sum = {2'b00, base} + {{CNT_WIDTH{1'b0}}, pend} + {{(CNT_WIDTH+1){1'b0}}, one};
      if (sum[CNT_WIDTH+1:CNT_WIDTH] != 2'b00) begin
         return {CNT_WIDTH{1'b1}};
      end else begin
         return sum[CNT_WIDTH-1:0];
      end
   endfunction

   // Stream valid and read issue; a same-cycle transfer credits buffer space.
   always_comb begin
      m_valid_s        = 1'b0;
      xfer_s           = 1'b0;
      rd_en_s          = 1'b0;
      cnt_after_xfer_s = buf_cnt_r;
      occ_s            = 3'd0;
      if (rst) begin
         rd_en_s = 1'b0;
      end else if (state_r == ST_RUN) begin
         m_valid_s        = (buf_cnt_r != 2'd0);
         xfer_s           = m_valid_s && m.m_ready;
         cnt_after_xfer_s = buf_cnt_r - {1'b0, xfer_s};
         occ_s            = {1'b0, cnt_after_xfer_s} + {2'b00, inflight_r};
         rd_en_s          = !lifo_empty && (occ_s < 3'd2);
      end else begin
         rd_en_s = !lifo_empty;
      end
   end

   assign lifo_rd_en = rd_en_s;
   assign m.m_valid  = m_valid_s;
   assign m.m_data   = buf0_r;
   assign flush_busy = (state_r == ST_FLUSH);
   assign drop_cnt   = drop_cnt_r;

   // Buffer, in-flight tracking, RUN/FLUSH sequencing and discard counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_RUN;
         buf_cnt_r   <= 2'd0;
         inflight_r  <= 1'b0;
         buf0_r      <= {DATA_WIDTH{1'b0}};
         buf1_r      <= {DATA_WIDTH{1'b0}};
         drop_pend_r <= 2'd0;
         drop_cnt_r  <= {CNT_WIDTH{1'b0}};
      end else begin
         inflight_r <= rd_en_s;
         case (state_r)
            ST_RUN: begin
               if (flush) begin
                  // Buffered and arriving entries are charged on the first FLUSH cycle.
                  state_r     <= ST_FLUSH;
                  buf_cnt_r   <= 2'd0;
                  drop_cnt_r  <= {CNT_WIDTH{1'b0}};
                  drop_pend_r <= cnt_after_xfer_s + {1'b0, inflight_r};
               end else begin
                  buf_cnt_r <= cnt_after_xfer_s + {1'b0, inflight_r};
                  if (xfer_s) begin
                     buf0_r <= buf1_r;
                  end
                  if (inflight_r) begin
                     if (cnt_after_xfer_s == 2'd0) begin
                        buf0_r <= lifo_data_rd;
                     end else begin
                        buf1_r <= lifo_data_rd;
                     end
                  end
               end
            end
            ST_FLUSH: begin
               drop_cnt_r  <= sat_add(drop_cnt_r, drop_pend_r, inflight_r);
               drop_pend_r <= 2'd0;
               if (lifo_empty && !inflight_r) begin
                  state_r <= ST_RUN;
               end
            end
            default: begin
               state_r <= ST_RUN;
            end
         endcase
      end
   end

endmodule
